// File: rtl/serial101_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial101_pkg
// Description : Shared types and constants for the 1-0-1 serial link transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial101_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [2:0] PREAMBLE = 3'b101;
    localparam int         PRE_LEN  = 3;

    // One counter is shared by PRE, DATA and GAP, so it must hold the longest phase.
    function automatic int cnt_width(input int data_w, input int gap_cyc);
        int m;
        m = PRE_LEN;
        if (data_w > m) m = data_w;
        if (gap_cyc > m) m = gap_cyc;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shreg.sv
`default_nettype none
// ============================================================================
// Module      : piso_shreg
// Description : Parallel-load, shift-left register exposing its next MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              msb_next_o
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [DATA_W-1:0] w_shifted;

    generate
        if (DATA_W == 1) begin : g_single
            assign w_shifted = '0;
        end else begin : g_multi
            assign w_shifted = {shreg_q[DATA_W-2:0], 1'b0};
        end
    endgenerate

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = w_shifted;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // The parent registers tx from next-cycle values, so it needs the post-update MSB.
    assign msb_next_o = shreg_d[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/serial101_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial101_tx
// Description : Frames a parallel word as preamble 101, payload MSB first, idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module serial101_tx
    import serial101_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W    = cnt_width(DATA_W, GAP_CYC);
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    localparam logic [CNT_W-1:0] C_PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_LAST);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             w_load;
    logic             w_shift;
    logic             w_msb_next;
    logic [2:0]       w_pre_sh;

    piso_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_load),
        .shift_i    (w_shift),
        .data_i     (data_i),
        .msb_next_o (w_msb_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_load  = 1'b0;
        w_shift = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i && ready_q) begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                    w_load  = 1'b1;
                end
            end
            ST_PRE: begin
                if (cnt_q == C_PRE_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                w_shift = 1'b1;
                if (cnt_q == C_DATA_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so every one of them is a flop.
    assign w_pre_sh = PREAMBLE << cnt_d;

    always_comb begin
        tx_d = 1'b0;
        case (state_d)
            ST_PRE:  tx_d = w_pre_sh[PRE_LEN-1];
            ST_DATA: tx_d = w_msb_next;
            default: tx_d = 1'b0;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_o    = tx_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial101_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial101_tx
// Description : Self-checking bench for serial101_tx (8-bit/gap 2 and 1-bit/gap 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial101_tx;

    typedef struct {
        logic tx;
        logic ready;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic [12:0] seq;
        bit          swap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data8;
    logic       valid8;
    logic       ready8, tx8, busy8, done8;
    logic [0:0] data1;
    logic       valid1;
    logic       ready1, tx1, busy1, done1;

    int checks = 0;
    int errors = 0;

    exp_t q8[$];
    exp_t q1[$];
    vec_t vecs[3];

    always #5 clk = ~clk;

    serial101_tx #(.DATA_W(8), .GAP_CYC(2)) u_dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data8),
        .valid_i (valid8),
        .ready_o (ready8),
        .tx_o    (tx8),
        .busy_o  (busy8),
        .done_o  (done8)
    );

    serial101_tx #(.DATA_W(1), .GAP_CYC(0)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data1),
        .valid_i (valid1),
        .ready_o (ready1),
        .tx_o    (tx1),
        .busy_o  (busy1),
        .done_o  (done1)
    );

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame of 13 line bits, done on the first gap cycle, then one ready cycle.
    task automatic push_frame8(input logic [12:0] seq);
        for (int k = 0; k < 13; k++) begin
            q8.push_back('{tx: seq[12-k], ready: 1'b0, busy: 1'b1, done: (k == 11)});
        end
        q8.push_back('{tx: 1'b0, ready: 1'b1, busy: 1'b0, done: 1'b0});
    endtask

    // With GAP_CYC=0 done lands on the first ready cycle.
    task automatic push_frame1(input logic [3:0] seq);
        for (int k = 0; k < 4; k++) begin
            q1.push_back('{tx: seq[3-k], ready: 1'b0, busy: 1'b1, done: 1'b0});
        end
        q1.push_back('{tx: 1'b0, ready: 1'b1, busy: 1'b0, done: 1'b1});
    endtask

    task automatic chk8();
        exp_t e;
        @(negedge clk);
        if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb8_empty: got empty queue, expected an entry at t=%0t", $time);
        end else begin
            e = q8.pop_front();
            cmp("tx8", tx8, e.tx);
            cmp("ready8", ready8, e.ready);
            cmp("busy8", busy8, e.busy);
            cmp("done8", done8, e.done);
        end
    endtask

    task automatic chk1();
        exp_t e;
        @(negedge clk);
        if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb1_empty: got empty queue, expected an entry at t=%0t", $time);
        end else begin
            e = q1.pop_front();
            cmp("tx1", tx1, e.tx);
            cmp("ready1", ready1, e.ready);
            cmp("busy1", busy1, e.busy);
            cmp("done1", done1, e.done);
        end
    endtask

    task automatic chk_all_zero();
        cmp("rst_tx8", tx8, 1'b0);
        cmp("rst_ready8", ready8, 1'b0);
        cmp("rst_busy8", busy8, 1'b0);
        cmp("rst_done8", done8, 1'b0);
        cmp("rst_tx1", tx1, 1'b0);
        cmp("rst_ready1", ready1, 1'b0);
        cmp("rst_busy1", busy1, 1'b0);
        cmp("rst_done1", done1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, seq: 13'b101_10100101_00, swap: 1'b0};
        vecs[1] = '{data: 8'h3C, seq: 13'b101_00111100_00, swap: 1'b0};
        vecs[2] = '{data: 8'h81, seq: 13'b101_10000001_00, swap: 1'b1};

        rst    = 1'b1;
        valid8 = 1'b1;
        data8  = 8'hA5;
        valid1 = 1'b1;
        data1  = 1'b1;

        // Reset held for two cycles with valid asserted
        repeat (2) begin
            @(negedge clk);
            chk_all_zero();
        end
        rst    = 1'b0;
        valid8 = 1'b0;
        valid1 = 1'b0;
        #1;
        cmp("ready8_pre_edge", ready8, 1'b0);
        @(negedge clk);
        cmp("ready8_after_release", ready8, 1'b1);
        cmp("ready1_after_release", ready1, 1'b1);

        // Single frames from the vector table
        foreach (vecs[i]) begin
            data8  = vecs[i].data;
            valid8 = 1'b1;
            push_frame8(vecs[i].seq);
            chk8();
            valid8 = 1'b0;
            if (vecs[i].swap) data8 = 8'h00;
            repeat (13) chk8();
        end

        // Back-to-back with valid held high throughout
        data8  = 8'hFF;
        valid8 = 1'b1;
        push_frame8(13'b101_11111111_00);
        push_frame8(13'b101_00000000_00);
        chk8();
        data8 = 8'h00;
        repeat (13) chk8();
        chk8();
        valid8 = 1'b0;
        repeat (13) chk8();

        // Reset during a payload bit
        data8  = 8'hFF;
        valid8 = 1'b1;
        push_frame8(13'b101_11111111_00);
        chk8();
        valid8 = 1'b0;
        repeat (7) chk8();
        #1 rst = 1'b1;
        #1;
        cmp("async_tx8", tx8, 1'b0);
        cmp("async_busy8", busy8, 1'b0);
        cmp("async_done8", done8, 1'b0);
        q8.delete();
        @(posedge clk);
        @(negedge clk);
        cmp("midrst_done8", done8, 1'b0);
        cmp("midrst_busy8", busy8, 1'b0);
        rst = 1'b0;
        #1;
        cmp("midrst_ready8_pre_edge", ready8, 1'b0);
        q8.push_back('{tx: 1'b0, ready: 1'b1, busy: 1'b0, done: 1'b0});
        chk8();
        data8  = 8'h5A;
        valid8 = 1'b1;
        push_frame8(13'b101_01011010_00);
        chk8();
        valid8 = 1'b0;
        repeat (13) chk8();

        // DATA_W=1, GAP_CYC=0 with immediate re-accept
        data1  = 1'b1;
        valid1 = 1'b1;
        push_frame1(4'b1011);
        push_frame1(4'b1010);
        chk1();
        data1 = 1'b0;
        repeat (4) chk1();
        chk1();
        valid1 = 1'b0;
        repeat (4) chk1();
        q1.push_back('{tx: 1'b0, ready: 1'b1, busy: 1'b0, done: 1'b0});
        chk1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
